mpu_irq_gen: RTL and testbench
==============================

Name: mpu_irq_gen

Overview:
MPU-side initiator of the MPU interrupt handshake.
- Queues interrupt events (64-bit payload) raised by the MPU execution core.
- Issues them one at a time as a 1-cycle `irq` pulse with stable `data`.
- Holds each event until the host-side interrupt unit drops `en` (accepted) and raises it again (committed by the main processor), then pops the event.
- Sits between the MPU core and the host-side interrupt unit.

Parameters:
DEPTH, 4, pending-event FIFO depth; power of two, 2..16
DATA_W, 64, payload width; must equal host-side `data` width
TIMEOUT, 255, cycles to wait for `en` low after `irq` (used only with MPU_IRQ_GEN_RETRY_EN)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  reset, asynchronous assert, active-low
req  in  1  MPU core event strobe; one event per cycle high
req_data  in  DATA_W  event payload, sampled when req=1
req_ready  out  1  FIFO not full
irq  out  1  interrupt pulse to host-side unit, exactly 1 cycle per issue
data  out  DATA_W  payload of head event; stable from issue until pop
en  in  1  host-side enable; low = event accepted, not yet committed
busy  out  1  an event is in flight (state != IDLE)
pending  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: req seen while full; cleared only by reset

Behaviour:
- Reset (async, sys_rst_n=0) forces:
  - state IDLE, FIFO empty, rd/wr pointers 0
  - irq=0, data=0, busy=0, pending=0, overflow=0, req_ready=1
- Reset mid-handshake abandons the in-flight event and all queued events; nothing is re-issued.
- FIFO:
  - Push when req && !full. `req_ready` = !full, registered occupancy; pop in the same cycle does NOT free a slot for that cycle's push.
  - req while full: event dropped, overflow<=1, FIFO unchanged.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally.
  - Occupancy counter updated as +1 push / -1 pop / 0 both.
- data = FIFO[rd_ptr] when non-empty, else 0. Combinational from registered storage; a push to an empty FIFO shows on data the next cycle.
- FSM:
  - IDLE: if !empty && en==1 -> FIRE. If en==0 (host still busy), stay.
  - FIRE: irq=1 this cycle only -> WAIT_LOW.
  - WAIT_LOW: en==0 -> WAIT_HIGH. Else stay (see optional feature).
  - WAIT_HIGH: en==1 -> pop head, go to IDLE.
- Latency:
  - Event pushed into an empty FIFO with en=1: push at cycle t, IDLE->FIRE at t+1, irq=1 at t+2.
  - Back-to-back events: irq to next irq is at least 4 cycles plus host hold time.
- `en` is a level; no edge detection on `en` outside WAIT_LOW/WAIT_HIGH.
- busy=1 in FIRE, WAIT_LOW, WAIT_HIGH.

Optional Feature:
MPU_IRQ_GEN_RETRY_EN
- Defined:
  - A counter starts at 0 on entering WAIT_LOW.
  - If en stays 1 for TIMEOUT cycles, FSM returns to FIRE and irq re-pulses with the same data (same head event).
  - Adds output `retries` (8-bit, saturating, reset 0), incremented per re-fire.
- Undefined: WAIT_LOW waits indefinitely; no counter, no `retries` port.

Decomposition:
- Package `mpu_irq_pkg`:
  - state enum {IDLE, FIRE, WAIT_LOW, WAIT_HIGH} (2 bits)
  - DATA_W default constant
  - TIMEOUT default constant
- Sub-module `mpu_irq_fifo`:
  - parameterised DEPTH/DATA_W sync FIFO with async active-low reset
  - push/pop/full/empty/count/head outputs
- FSM and optional retry counter live in mpu_irq_gen.

Test Plan:
1. Single event: reset, en tied to host model (drops 1 cycle after irq, raises 4 cycles later); req with req_data=64'hDEAD_BEEF_0000_0001 -> one irq pulse, data holds value until en rises, pending 1->0, busy falls the cycle after pop.
2. Fill FIFO: DEPTH=4, hold en=0, push 5 events -> req_ready=0 after 4th, 5th dropped, overflow=1, pending=4. Release en=1 -> 4 irqs in push order, payloads 1..4.
3. Wrap-around: push/commit 10 sequential payloads 0..9 with random host delays -> irq payloads in order, no loss, pending ends 0.
4. en=0 at idle: event queued while en=0 -> no irq until en=1; irq appears 1 cycle after en rises.
5. Reset mid-handshake: assert sys_rst_n=0 in WAIT_HIGH with 2 queued -> all outputs to reset values immediately; after release no irq without new req.
6. With MPU_IRQ_GEN_RETRY_EN, TIMEOUT=8: host ignores first irq -> second irq exactly 9 cycles after first, same data, retries=1. Host then acks -> normal pop.

Source files
------------

// File: rtl/mpu_irq_pkg.sv
// Shared types and defaults for the MPU interrupt initiator.
// The retry feature is enabled by defining MPU_IRQ_GEN_RETRY_EN.
package mpu_irq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FIRE      = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } irq_state_e;

    localparam int DATA_W_DEF  = 64;
    localparam int TIMEOUT_DEF = 255;
    localparam int RETRY_W     = 8;

endpackage

// File: rtl/mpu_irq_fifo.sv
// Pending-event FIFO: power-of-two depth, registered occupancy, combinational head.
// The head reads as zero whenever the FIFO is empty.
module mpu_irq_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic                   pop_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [DATA_W-1:0]      head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    // Full/empty come from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mpu_irq_gen.sv
// MPU-side interrupt initiator: queues core events and issues them one at a time
// to the host unit. Define MPU_IRQ_GEN_RETRY_EN to re-fire an unacknowledged irq.
module mpu_irq_gen
    import mpu_irq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF
`ifdef MPU_IRQ_GEN_RETRY_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   req,
    input  logic [DATA_W-1:0]      req_data,
    output logic                   req_ready,
    output logic                   irq,
    output logic [DATA_W-1:0]      data,
    input  logic                   en,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   overflow,
`ifdef MPU_IRQ_GEN_RETRY_EN
    output logic [RETRY_W-1:0]     retries,
`endif
    output logic [1:0]             state_dbg
);

    // Handshake: the core pushes when req && req_ready; irq is a one-cycle
    // issue strobe with data stable until the host drops en (accept) and
    // raises it again (commit), at which point the head event is popped.

    irq_state_e state_q;
    logic       irq_q;
    logic       busy_q;
    logic       overflow_q;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;

`ifdef MPU_IRQ_GEN_RETRY_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

    logic [CNT_W-1:0]   wait_cnt_q;
    logic [RETRY_W-1:0] retries_q;
`endif

    assign fifo_push = req && !fifo_full;
    assign fifo_pop  = (state_q == WAIT_HIGH) && en;

    mpu_irq_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .push_i  (fifo_push),
        .wdata_i (req_data),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (pending),
        .head_o  (data)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overflow_q <= 1'b0;
        end else if (req && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    // irq_q and busy_q are updated alongside the state so they mirror
    // "state == FIRE" and "state != IDLE" without a decode stage.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef MPU_IRQ_GEN_RETRY_EN
            wait_cnt_q <= '0;
            retries_q  <= '0;
`endif
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && en) begin
                        state_q <= FIRE;
                        irq_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                FIRE: begin
                    state_q <= WAIT_LOW;
`ifdef MPU_IRQ_GEN_RETRY_EN
                    wait_cnt_q <= '0;
`endif
                end
                WAIT_LOW: begin
                    if (!en) begin
                        state_q <= WAIT_HIGH;
                    end
`ifdef MPU_IRQ_GEN_RETRY_EN
                    else if (wait_cnt_q == CNT_LAST) begin
                        state_q <= FIRE;
                        irq_q   <= 1'b1;
                        if (retries_q != '1) begin
                            retries_q <= retries_q + RETRY_ONE;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_ONE;
                    end
`endif
                end
                WAIT_HIGH: begin
                    if (en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = !fifo_full;
    assign irq       = irq_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;
`ifdef MPU_IRQ_GEN_RETRY_EN
    assign retries   = retries_q;
`endif

endmodule

// File: tb/tb_mpu_irq_gen.sv
// Bench for mpu_irq_gen: randomized traffic and host timing checked cycle by cycle
// against a transaction-level model of the queue and the en handshake.
`timescale 1ns/1ps
module tb_mpu_irq_gen;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;
    localparam int PW     = $clog2(DEPTH) + 1;
`ifdef MPU_IRQ_GEN_RETRY_EN
    localparam int TIMEOUT = 8;
`endif

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              req       = 1'b0;
    logic [DATA_W-1:0] req_data  = '0;
    logic              en        = 1'b1;
    logic              req_ready;
    logic              irq;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic [PW-1:0]     pending;
    logic              overflow;
    logic [1:0]        state_dbg;
`ifdef MPU_IRQ_GEN_RETRY_EN
    logic [7:0]        retries;
`endif

    always #5 sys_clk = ~sys_clk;

    mpu_irq_gen #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
`ifdef MPU_IRQ_GEN_RETRY_EN
        ,
        .TIMEOUT(TIMEOUT)
`endif
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .req_data  (req_data),
        .req_ready (req_ready),
        .irq       (irq),
        .data      (data),
        .en        (en),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow),
`ifdef MPU_IRQ_GEN_RETRY_EN
        .retries   (retries),
`endif
        .state_dbg (state_dbg)
    );

    // Reference model: exp_q holds every accepted event, head = in flight.
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    bit m_irq;
    bit m_busy;
    bit m_low_seen;
    bit m_ovf;
    int m_wait;
    int m_retries;

    int n_checks;
    int n_fail;
    int cyc;
    int last_irq_cyc;

    // Host model: after an irq, drop en after host_drop cycles, hold low host_low cycles.
    bit   host_auto;
    logic en_force;
    int   host_drop;
    int   host_low;
    int   h_drop_fix;
    int   h_hold_fix;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_irq      = 1'b0;
        m_busy     = 1'b0;
        m_low_seen = 1'b0;
        m_ovf      = 1'b0;
        m_wait     = 0;
        m_retries  = 0;
        host_drop  = 0;
        host_low   = 0;
    endtask

    // One clock cycle: drive host, check outputs at negedge, advance the model.
    task automatic cycle();
        logic [DATA_W-1:0] exp_data;
        int sz;
        bit next_irq;
        if (host_auto) begin
            if (host_drop > 0) begin
                host_drop--;
                if (host_drop == 0) en = 1'b0;
            end else if (host_low > 0) begin
                host_low--;
                if (host_low == 0) en = 1'b1;
            end else begin
                en = 1'b1;
            end
        end else begin
            en = en_force;
        end

        @(negedge sys_clk);
        sz = exp_q.size();
        exp_data = (sz > 0) ? exp_q[0] : '0;
        check_eq("irq", 64'(irq), 64'(m_irq));
        check_eq("busy", 64'(busy), 64'(m_busy));
        check_eq("pending", 64'(pending), 64'(sz));
        check_eq("req_ready", 64'(req_ready), 64'(sz < DEPTH));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("data", data, exp_data);
`ifdef MPU_IRQ_GEN_RETRY_EN
        check_eq("retries", 64'(retries), 64'(m_retries));
`endif
        if (irq) begin
            last_irq_cyc = cyc;
            got_q.push_back(data);
            if (host_auto) begin
                host_drop = (h_drop_fix > 0) ? h_drop_fix : int'($urandom_range(1, 3));
                host_low  = (h_hold_fix > 0) ? h_hold_fix : int'($urandom_range(1, 5));
            end
        end

        next_irq = 1'b0;
        if (m_irq) begin
            m_low_seen = 1'b0;
            m_wait     = 0;
        end else if (m_busy && !m_low_seen) begin
            if (!en) m_low_seen = 1'b1;
`ifdef MPU_IRQ_GEN_RETRY_EN
            else if (m_wait == TIMEOUT - 1) begin
                next_irq = 1'b1;
                if (m_retries < 255) m_retries++;
            end else m_wait++;
`endif
        end else if (m_busy) begin
            if (en) begin
                void'(exp_q.pop_front());
                m_busy = 1'b0;
            end
        end else if (sz > 0 && en) begin
            next_irq = 1'b1;
            m_busy   = 1'b1;
        end
        if (req) begin
            if (sz < DEPTH) exp_q.push_back(req_data);
            else m_ovf = 1'b1;
        end
        m_irq = next_irq;

        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        req = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        check_eq("rst_irq", 64'(irq), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_pending", 64'(pending), 64'(0));
        check_eq("rst_overflow", 64'(overflow), 64'(0));
        check_eq("rst_req_ready", 64'(req_ready), 64'(1));
        check_eq("rst_data", data, 64'(0));
        model_reset();
        en = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        req = 1'b0;
        while ((exp_q.size() != 0 || m_busy) && i < budget) begin
            cycle();
            i++;
        end
        check_eq("drain_pending", 64'(pending), 64'(0));
        check_eq("drain_busy", 64'(busy), 64'(0));
    endtask

    task automatic push_one(input logic [DATA_W-1:0] val);
        req = 1'b1;
        req_data = val;
        cycle();
        req = 1'b0;
    endtask

    initial begin
        int push_cyc;
        int rise_cyc;
        int k;
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        last_irq_cyc = -100;
        host_auto = 1'b1;
        en_force = 1'b1;
        h_drop_fix = 0;
        h_hold_fix = 0;
        model_reset();
        @(posedge sys_clk);
        #1;
        do_reset();

        // Single event with a host that drops en after 1 cycle and holds it 4 cycles.
        h_drop_fix = 1;
        h_hold_fix = 4;
        push_cyc = cyc;
        push_one(64'hDEAD_BEEF_0000_0001);
        drain(40);
        check_eq("t1_latency", 64'(last_irq_cyc - push_cyc), 64'(2));
        h_drop_fix = 0;
        h_hold_fix = 0;

        // Fill with en held low: fifth event is dropped.
        host_auto = 1'b0;
        en_force = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            req = 1'b1;
            req_data = DATA_W'(i);
            cycle();
        end
        req = 1'b0;
        check_eq("t2_pending", 64'(pending), 64'(4));
        check_eq("t2_overflow", 64'(overflow), 64'(1));
        check_eq("t2_req_ready", 64'(req_ready), 64'(0));
        got_q.delete();
        host_auto = 1'b1;
        drain(200);
        check_eq("t2_irq_count", 64'(got_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check_eq("t2_order", got_q[i], 64'(i + 1));
        end

        // Wrap-around: ten sequential payloads with random gaps and host timing.
        got_q.delete();
        k = 0;
        for (int i = 0; i < 2000 && (k < 10 || exp_q.size() != 0 || m_busy); i++) begin
            if (k < 10 && exp_q.size() < DEPTH && $urandom_range(0, 2) == 0) begin
                req = 1'b1;
                req_data = DATA_W'(k);
                k++;
            end else begin
                req = 1'b0;
            end
            cycle();
        end
        req = 1'b0;
        check_eq("t3_irq_count", 64'(got_q.size()), 64'(10));
        for (int i = 0; i < 10; i++) begin
            if (i < got_q.size()) check_eq("t3_order", got_q[i], 64'(i));
        end
        check_eq("t3_pending", 64'(pending), 64'(0));

        // Event queued while the host holds en low.
        host_auto = 1'b0;
        en_force = 1'b0;
        push_one(64'h0000_A5A5_5A5A_0000);
        for (int i = 0; i < 5; i++) cycle();
        en_force = 1'b1;
        rise_cyc = cyc;
        cycle();
        host_auto = 1'b1;
        drain(40);
        check_eq("t4_irq_after_en", 64'(last_irq_cyc - rise_cyc), 64'(1));

        // Randomized traffic and host timing.
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 1) == 1);
            req_data = {$urandom(), $urandom()};
            cycle();
        end
        req = 1'b0;
        drain(400);

        // Reset while waiting for en to rise, with two more events queued.
        host_auto = 1'b0;
        en_force = 1'b0;
        for (int i = 0; i < 3; i++) push_one(64'h1000 + 64'(i));
        en_force = 1'b1;
        for (int i = 0; i < 10 && !m_busy; i++) cycle();
        en_force = 1'b0;
        for (int i = 0; i < 10 && !m_low_seen; i++) cycle();
        check_eq("t5_pre_pending", 64'(pending), 64'(3));
        check_eq("t5_pre_busy", 64'(busy), 64'(1));
        do_reset();
        host_auto = 1'b1;
        got_q.delete();
        for (int i = 0; i < 12; i++) cycle();
        check_eq("t5_no_reissue", 64'(got_q.size()), 64'(0));

`ifdef MPU_IRQ_GEN_RETRY_EN
        // Host ignores the first irq; it must re-fire TIMEOUT+1 cycles later.
        begin
            int first_irq;
            host_auto = 1'b0;
            en_force = 1'b1;
            push_one(64'hCAFE_0000_0000_0006);
            for (int i = 0; i < 10 && last_irq_cyc < 0; i++) cycle();
            for (int i = 0; i < 10 && !m_irq; i++) cycle();
            cycle();
            first_irq = last_irq_cyc;
            for (int i = 0; i < 30 && last_irq_cyc == first_irq; i++) cycle();
            check_eq("t6_refire_gap", 64'(last_irq_cyc - first_irq), 64'(TIMEOUT + 1));
            check_eq("t6_retries", 64'(retries), 64'(1));
            host_auto = 1'b1;
            h_drop_fix = 1;
            h_hold_fix = 2;
            drain(60);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
